// File: rtl/fir_pkg.sv
// fir_pkg: operation codes and sequencer states shared by the FIR sequencer and cores
package fir_pkg;
  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_LOAD    = 2'b01,
    OP_COMPUTE = 2'b10,
    OP_READ    = 2'b11
  } fir_op_e;
  // State codes match the op codes so core_op is a plain cast of the state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LOAD    = 2'b01,
    ST_COMPUTE = 2'b10,
    ST_READ    = 2'b11
  } seq_state_e;
endpackage

// File: rtl/fir_sample_buf.sv
// fir_sample_buf: host-written sample register file with one combinational read port
module fir_sample_buf #(
  parameter int DATA_W    = 32,
  parameter int SIG_COUNT = 10,
  parameter int ADDR_W    = $clog2(SIG_COUNT)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [SIG_COUNT];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: drives a FIR core through load/compute/readout with timeout and pipelined reads
// The release request is named release_req because release is a reserved word.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SIG_COUNT = 10,
  parameter int ADDR_W    = $clog2(SIG_COUNT),
  parameter int CORE_LAT  = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              release_req,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        core_op,
  output logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_x,
  input  logic [DATA_W-1:0] core_y,
  input  logic              core_done
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIG_COUNT - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  seq_state_e state, state_n;
  logic [TW-1:0] timer;
  logic [CORE_LAT-1:0] vld;
  logic [ADDR_W-1:0] next_idx;
  logic [DATA_W-1:0] buf_q;
  logic start_acc, wr_ok, wr_bad, timeout, rd_acc, rd_fire;
  assign busy      = state == ST_LOAD || state == ST_COMPUTE;
  assign done      = state == ST_READ;
  assign core_op   = fir_op_e'(state);
  assign start_acc = start && !busy;
  assign wr_ok     = wr_en && !busy && wr_addr <= LAST;
  assign wr_bad    = wr_en && !wr_ok;
  assign timeout   = state == ST_COMPUTE && !core_done && timer == TMAX;
  assign rd_acc    = state_n == ST_READ && done && rd_en && rd_addr <= LAST;
  assign rd_fire   = vld[CORE_LAT-1] && state_n == ST_READ;
  assign next_idx  = (state == ST_LOAD && core_addr != LAST) ? core_addr + ADDR_W'(1) : '0;
  fir_sample_buf #(.DATA_W(DATA_W), .SIG_COUNT(SIG_COUNT), .ADDR_W(ADDR_W)) u_buf (
    .clk(clk), .we(wr_ok), .wa(wr_addr), .wd(wr_data), .ra(next_idx), .rd(buf_q)
  );
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    state_n = start ? ST_LOAD : ST_IDLE;
      ST_LOAD:    state_n = core_addr == LAST ? ST_COMPUTE : ST_LOAD;
      ST_COMPUTE: state_n = core_done ? ST_READ : (timer == TMAX ? ST_IDLE : ST_COMPUTE);
      ST_READ:    state_n = start ? ST_LOAD : (release_req ? ST_IDLE : ST_READ);
      default:    state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      vld       <= '0;
      err       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      core_addr <= '0;
      core_x    <= '0;
    end else begin
      state    <= state_n;
      timer    <= state == ST_COMPUTE ? timer + TW'(1) : '0;
      err      <= (err && !start_acc) || wr_bad || timeout;
      // Reads still in flight are flushed whenever READ is left.
      vld      <= state_n == ST_READ ? CORE_LAT'({vld, rd_acc}) : '0;
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= core_y;
      if (state_n == ST_LOAD) begin
        core_addr <= next_idx;
        core_x    <= buf_q;
      end else if (rd_acc) core_addr <= rd_addr;
      else if (state == ST_COMPUTE && state_n == ST_READ) core_addr <= '0;
    end
  end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: scoreboard bench for fir_seq_ctrl with a behavioural FIR core and sample buffer model
module tb_fir_seq_ctrl;
  localparam int DW = 32, N = 10, AW = 4;
  logic clk = 0, reset = 1, wr_en = 0, start = 0, rd_en = 0, release_req = 0, core_done = 0;
  logic [AW-1:0] wr_addr = 0, rd_addr = 0, core_addr;
  logic [DW-1:0] wr_data = 0, rd_data, core_x, core_y;
  logic busy, done, err, rd_valid;
  logic [1:0] core_op;
  logic [DW-1:0] model_buf [N];
  logic [DW-1:0] ld_d [$], rd_q [$];
  logic [AW-1:0] ld_a [$];
  int tests = 0, fails = 0;

  fir_seq_ctrl #(.DATA_W(DW), .SIG_COUNT(N), .ADDR_W(AW), .CORE_LAT(1), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_en(rd_en), .rd_addr(rd_addr), .release_req(release_req),
    .busy(busy), .done(done), .err(err), .rd_valid(rd_valid), .rd_data(rd_data),
    .core_op(core_op), .core_addr(core_addr), .core_x(core_x), .core_y(core_y),
    .core_done(core_done)
  );

  always #5 clk = ~clk;
  assign core_y = DW'(core_addr) * 3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic run(input int done_at, input bit inj, input bit rel,
                     output int nload, output int ncomp, output logic e0);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    ld_d = {}; ld_a = {};
    for (int i = 0; i < N; i++) begin ld_a.push_back(AW'(i)); ld_d.push_back(model_buf[i]); end
    nload = 0; ncomp = 0;
    start = 1; release_req = rel;
    @(negedge clk);
    start = 0; release_req = 0; e0 = err;
    for (int k = 0; k < 60; k++) begin
      if (core_op == 2'b11 || (ncomp > 0 && core_op == 2'b00)) break;
      core_done = 0; wr_en = 0; start = 0;
      if (core_op == 2'b01) begin
        tests++;
        if (ld_d.size() == 0) begin
          fails++;
          $display("FAIL load_extra: got addr %0d want no LOAD cycle", core_addr);
        end else begin
          ea = ld_a.pop_front(); ed = ld_d.pop_front();
          if ({core_addr, core_x} !== {ea, ed}) begin
            fails++;
            $display("FAIL load_sample: got addr %0d x %0h want addr %0d x %0h", core_addr, core_x, ea, ed);
          end
        end
        nload++;
        if (inj && nload == 3) begin wr_en = 1; wr_addr = 3; wr_data = 999; end
      end else if (core_op == 2'b10) begin
        ncomp++;
        if (done_at > 0 && ncomp == done_at) core_done = 1;
        if (inj && ncomp == 1) start = 1;
      end
      @(negedge clk);
    end
    core_done = 0; wr_en = 0; start = 0;
    chk("load_count", 128'(nload), 128'(N));
    chk("load_queue_empty", 128'(ld_d.size()), 0);
  endtask

  task automatic test_reset;
    chk("reset_values", {core_op, core_addr, core_x, rd_data, busy, done, err, rd_valid}, 0);
  endtask

  task automatic test_normal;
    int nl, nc;
    logic e0;
    for (int i = 0; i < N; i++) begin model_buf[i] = DW'(i); wr(AW'(i), DW'(i)); end
    chk("write_no_err", 128'(err), 0);
    run(5, 0, 0, nl, nc, e0);
    chk("normal_compute_len", 128'(nc), 5);
    chk("normal_read_state", {core_op, done, busy, core_addr}, {2'b11, 1'b1, 1'b0, 4'd0});
  endtask

  task automatic test_readout;
    logic [AW-1:0] al [4] = '{2, 7, 9, 12};
    logic [DW-1:0] e;
    int vcount = 0, first = -1, last = -1;
    for (int i = 0; i < 8; i++) begin
      if (rd_valid) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL rd_unexpected: got rd_data %0d want no rd_valid", rd_data);
        end else begin
          e = rd_q.pop_front();
          if (rd_data !== e) begin
            fails++;
            $display("FAIL rd_data: got %0d want %0d", rd_data, e);
          end
        end
        vcount++; last = i;
        if (first < 0) first = i;
      end
      rd_en = i < 4;
      rd_addr = i < 4 ? al[i] : '0;
      if (i < 4 && al[i] < N) rd_q.push_back(DW'(al[i]) * 3);
      @(negedge clk);
    end
    rd_en = 0;
    chk("rd_valid_count", 128'(vcount), 3);
    chk("rd_valid_consecutive", 128'(last - first), 2);
    chk("rd_queue_empty", 128'(rd_q.size()), 0);
  endtask

  task automatic test_restart_release;
    int nl, nc;
    logic e0;
    int vseen = 0;
    run(5, 0, 1, nl, nc, e0);
    chk("restart_read", {core_op, done}, {2'b11, 1'b1});
    release_req = 1;
    @(negedge clk);
    release_req = 0;
    chk("release_idle", {core_op, done, busy}, {2'b00, 1'b0, 1'b0});
    rd_en = 1; rd_addr = 2;
    @(negedge clk);
    rd_en = 0;
    for (int i = 0; i < 3; i++) begin
      if (rd_valid) vseen++;
      @(negedge clk);
    end
    chk("rd_outside_read", 128'(vseen), 0);
  endtask

  task automatic test_timeout;
    int nl, nc;
    logic e0;
    run(0, 0, 0, nl, nc, e0);
    chk("timeout_cycles", 128'(nc), 16);
    chk("timeout_state", {core_op, err, busy, done}, {2'b00, 1'b1, 1'b0, 1'b0});
    run(5, 0, 0, nl, nc, e0);
    chk("start_clears_err", 128'(e0), 0);
    chk("after_timeout_read", 128'(core_op), 128'(2'b11));
  endtask

  task automatic test_rejected;
    int nl, nc;
    logic e0;
    run(5, 1, 0, nl, nc, e0);
    chk("rejected_run_len", 128'(nc), 5);
    chk("rejected_err", {err, done}, {1'b1, 1'b1});
    release_req = 1;
    @(negedge clk);
    release_req = 0;
    run(5, 0, 0, nl, nc, e0);
    chk("clean_run_err", {e0, err}, 0);
    release_req = 1;
    @(negedge clk);
    release_req = 0;
    wr(AW'(10), 777);
    chk("bad_addr_err", 128'(err), 1);
  endtask

  task automatic test_reset_mid_load;
    int nl, nc;
    logic e0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 20; k++) begin
      if (core_op == 2'b01 && core_addr == 4) break;
      @(negedge clk);
    end
    chk("reached_sample4", {core_op, core_addr}, {2'b01, 4'd4});
    reset = 1;
    @(negedge clk);
    chk("mid_load_reset", {core_op, core_addr, core_x, rd_data, busy, done, err, rd_valid}, 0);
    reset = 0;
    run(5, 0, 0, nl, nc, e0);
    chk("post_reset_read", {core_op, done}, {2'b11, 1'b1});
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    test_reset;
    reset = 0;
    test_normal;
    test_readout;
    test_restart_release;
    test_timeout;
    test_rejected;
    test_reset_mid_load;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
